vc_dequeue_mux: RTL and testbench

Consumer side of the QoS round-robin arbiter. Takes the arbiter's one-hot 4-bit grant for virtual channels VC0..VC3, pops the granted show-ahead VC FIFO, and forwards the word to the link-side output register under a valid/ready handshake. Reports requests back to the arbiter, acknowledges served grants, and flags illegal or unserviceable grants.

---
 rtl/vc_dequeue_mux.sv | 136 +++++++++++++
 tb/tb_vc_dequeue_mux.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vc_dequeue_mux.sv
// vc_dequeue_mux: consumer side of the QoS round-robin arbiter.
// Pops the granted show-ahead VC FIFO and forwards its head word into a
// registered valid/ready output stage. Flags illegal grants and counts drops.
// Optional per-VC served counters are enabled by defining VC_STATS_EN.
module vc_dequeue_mux #(
    parameter int unsigned DATA_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [3:0]            grant,
    input  logic                  grant_valid,
    input  logic [3:0]            vc_empty,
    input  logic [DATA_WIDTH-1:0] vc_data0,
    input  logic [DATA_WIDTH-1:0] vc_data1,
    input  logic [DATA_WIDTH-1:0] vc_data2,
    input  logic [DATA_WIDTH-1:0] vc_data3,
    output logic [3:0]            vc_pop,
    output logic [3:0]            req,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_vc,
    output logic [3:0]            grant_ack,
    output logic                  err_illegal,
    output logic [7:0]            drop_cnt,
    output logic [31:0]           served_cnt
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [1:0]            out_vc_q;
    logic                  out_valid_q;
    logic [3:0]            grant_ack_q;
    logic                  err_illegal_q;
    logic [7:0]            drop_cnt_q;

    logic                  one_hot;
    logic                  legal;
    logic                  slot_free;
    logic                  accept;
    logic                  drop;
    logic [1:0]            gidx;
    logic [DATA_WIDTH-1:0] sel_data;

    // Grant decode: one-hot check, binary index and head-word select.
    always_comb begin
        one_hot = (grant != 4'b0000) && ((grant & (grant - 4'd1)) == 4'b0000);
        gidx    = 2'd0;
        case (grant)
            4'b0010: gidx = 2'd1;
            4'b0100: gidx = 2'd2;
            4'b1000: gidx = 2'd3;
            default: gidx = 2'd0;
        endcase
        case (gidx)
            2'd0:    sel_data = vc_data0;
            2'd1:    sel_data = vc_data1;
            2'd2:    sel_data = vc_data2;
            default: sel_data = vc_data3;
        endcase
        legal     = grant_valid && one_hot;
        slot_free = (state_q == StIdle) || out_ready;
        accept    = legal && slot_free && !vc_empty[gidx];
        drop      = legal && slot_free && vc_empty[gidx];
    end

    // Pop and request are gated by reset so nothing leaks while it is held.
    assign vc_pop = (reset_L && accept) ? grant : 4'b0000;
    assign req    = reset_L ? ~vc_empty : 4'b0000;

    // Output stage FSM: IDLE holds nothing, HOLD presents a word downstream.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q       <= StIdle;
            out_data_q    <= '0;
            out_vc_q      <= 2'd0;
            out_valid_q   <= 1'b0;
            grant_ack_q   <= 4'b0000;
            err_illegal_q <= 1'b0;
        end else begin
            grant_ack_q <= 4'b0000;
            if (grant_valid && !one_hot) begin
                err_illegal_q <= 1'b1;
            end
            if (accept) begin
                // Also covers the back-to-back replace while in HOLD.
                state_q     <= StHold;
                out_data_q  <= sel_data;
                out_vc_q    <= gidx;
                out_valid_q <= 1'b1;
                grant_ack_q <= grant;
            end else if (state_q == StHold && out_ready) begin
                state_q     <= StIdle;
                out_valid_q <= 1'b0;
            end
        end
    end

    // Saturating count of legal grants that hit an empty VC.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            drop_cnt_q <= 8'd0;
        end else if (drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign out_data    = out_data_q;
    assign out_vc      = out_vc_q;
    assign out_valid   = out_valid_q;
    assign grant_ack   = grant_ack_q;
    assign err_illegal = err_illegal_q;
    assign drop_cnt    = drop_cnt_q;

`ifdef VC_STATS_EN
    logic [7:0] served_q [4];

    // Per-VC saturating count of accepted grants.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) begin
                served_q[i] <= 8'd0;
            end
        end else if (accept && served_q[gidx] != 8'hFF) begin
            served_q[gidx] <= served_q[gidx] + 8'd1;
        end
    end

    assign served_cnt = {served_q[3], served_q[2], served_q[1], served_q[0]};
`else
    assign served_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_vc_dequeue_mux.sv
// Directed testbench for vc_dequeue_mux. Expected values are hand-computed.
// Honours VC_STATS_EN for the served-counter expectations.
module tb_vc_dequeue_mux;

    logic        clk = 1'b0;
    logic        reset_L;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [3:0]  vc_empty;
    logic [5:0]  vc_data0, vc_data1, vc_data2, vc_data3;
    logic [3:0]  vc_pop;
    logic [3:0]  req;
    logic [5:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_vc;
    logic [3:0]  grant_ack;
    logic        err_illegal;
    logic [7:0]  drop_cnt;
    logic [31:0] served_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vc_dequeue_mux #(.DATA_WIDTH(6)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .grant      (grant),
        .grant_valid(grant_valid),
        .vc_empty   (vc_empty),
        .vc_data0   (vc_data0),
        .vc_data1   (vc_data1),
        .vc_data2   (vc_data2),
        .vc_data3   (vc_data3),
        .vc_pop     (vc_pop),
        .req        (req),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vc     (out_vc),
        .grant_ack  (grant_ack),
        .err_illegal(err_illegal),
        .drop_cnt   (drop_cnt),
        .served_cnt (served_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  g_seq [4];
    logic [5:0]  d_seq [4];
    int          pops;
    logic [31:0] served_exp;

    initial begin
        g_seq[0] = 4'b0001; g_seq[1] = 4'b0010; g_seq[2] = 4'b0100; g_seq[3] = 4'b1000;
        d_seq[0] = 6'h11;   d_seq[1] = 6'h22;   d_seq[2] = 6'h2A;   d_seq[3] = 6'h33;

        reset_L     = 1'b0;
        grant       = 4'b0000;
        grant_valid = 1'b0;
        vc_empty    = 4'b0000;
        vc_data0    = 6'h11;
        vc_data1    = 6'h22;
        vc_data2    = 6'h2A;
        vc_data3    = 6'h33;
        out_ready   = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_req", {28'd0, req}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
        chk("rst_err", {31'd0, err_illegal}, 32'd0);
        step();
        reset_L = 1'b1;

        // Single accept from VC2
        grant = 4'b0100; grant_valid = 1'b1;
        #1;
        chk("t1_pop", {28'd0, vc_pop}, 32'h4);
        chk("t1_req", {28'd0, req}, 32'hF);
        step();
        chk("t1_data", {26'd0, out_data}, 32'h2A);
        chk("t1_vc", {30'd0, out_vc}, 32'd2);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_ack", {28'd0, grant_ack}, 32'h4);

        // Back-to-back grants on all four VCs
        for (int i = 0; i < 4; i++) begin
            grant = g_seq[i];
            #1;
            chk("t2_pop", {28'd0, vc_pop}, {28'd0, g_seq[i]});
            step();
            chk("t2_data", {26'd0, out_data}, {26'd0, d_seq[i]});
            chk("t2_vc", {30'd0, out_vc}, i);
            chk("t2_valid", {31'd0, out_valid}, 32'd1);
            chk("t2_ack", {28'd0, grant_ack}, {28'd0, g_seq[i]});
        end
        grant_valid = 1'b0;
        #1;
        chk("t2_pop_idle", {28'd0, vc_pop}, 32'd0);
        step();
        chk("t2_valid_low", {31'd0, out_valid}, 32'd0);
        chk("t2_ack_low", {28'd0, grant_ack}, 32'd0);

        // Backpressure: word from VC0 held for three cycles
        grant = 4'b0001; grant_valid = 1'b1;
        step();
        chk("t3_data0", {26'd0, out_data}, 32'h11);
        out_ready = 1'b0;
        grant     = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_pop_stall", {28'd0, vc_pop}, 32'd0);
            step();
            chk("t3_data_held", {26'd0, out_data}, 32'h11);
            chk("t3_valid_held", {31'd0, out_valid}, 32'd1);
            chk("t3_ack_stall", {28'd0, grant_ack}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_pop_release", {28'd0, vc_pop}, 32'h2);
        step();
        chk("t3_data_new", {26'd0, out_data}, 32'h22);
        chk("t3_vc_new", {30'd0, out_vc}, 32'd1);
        grant_valid = 1'b0;
        step();
        chk("t3_drop_none", {24'd0, drop_cnt}, 32'd0);

        // Illegal grant sets the sticky error
        grant = 4'b0011; grant_valid = 1'b1;
        #1;
        chk("t4_pop_illegal", {28'd0, vc_pop}, 32'd0);
        step();
        chk("t4_err", {31'd0, err_illegal}, 32'd1);
        chk("t4_valid", {31'd0, out_valid}, 32'd0);
        grant = 4'b0001;
        #1;
        chk("t4_pop_legal", {28'd0, vc_pop}, 32'h1);
        step();
        chk("t4_err_sticky", {31'd0, err_illegal}, 32'd1);
        chk("t4_data", {26'd0, out_data}, 32'h11);
        grant_valid = 1'b0;
        step();

        // Grants to an empty VC saturate the drop counter
        vc_empty = 4'b1000;
        grant = 4'b1000; grant_valid = 1'b1;
        #1;
        chk("t5_req", {28'd0, req}, 32'h7);
        pops = 0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (vc_pop != 4'b0000) pops++;
            step();
            if (i == 0) chk("t5_drop_first", {24'd0, drop_cnt}, 32'd1);
        end
        chk("t5_pops", pops, 32'd0);
        chk("t5_drop_sat", {24'd0, drop_cnt}, 32'd255);
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        grant_valid = 1'b0;

        // Served counters over a long VC1 burst, then reset mid-burst
        reset_L = 1'b0;
        step();
        reset_L  = 1'b1;
        vc_empty = 4'b0000;
        grant = 4'b0010; grant_valid = 1'b1;
        for (int i = 0; i < 260; i++) step();
`ifdef VC_STATS_EN
        served_exp = 32'h0000FF00;
`else
        served_exp = 32'h0;
`endif
        chk("t6_served", served_cnt, served_exp);
        chk("t6_valid_burst", {31'd0, out_valid}, 32'd1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_data", {26'd0, out_data}, 32'd0);
        chk("t6_rst_vc", {30'd0, out_vc}, 32'd0);
        chk("t6_rst_ack", {28'd0, grant_ack}, 32'd0);
        chk("t6_rst_pop", {28'd0, vc_pop}, 32'd0);
        chk("t6_rst_req", {28'd0, req}, 32'd0);
        chk("t6_rst_served", served_cnt, 32'd0);
        chk("t6_rst_drop", {24'd0, drop_cnt}, 32'd0);
        step();
        reset_L = 1'b1;
        #1;
        chk("t6_pop_after", {28'd0, vc_pop}, 32'h2);
        step();
        chk("t6_valid_after", {31'd0, out_valid}, 32'd1);
        chk("t6_data_after", {26'd0, out_data}, 32'h22);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
